// File: rtl/ihp_clk_gate_ctrl.sv
// Per-domain automatic clock-gating controller: gates idle domains after a shared
// threshold and re-enables them on demand with a fixed settle delay before ready.
module ihp_clk_gate_ctrl #(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_en_i,
  output logic               test_en_o,
  input  logic [NUM_DOM-1:0] cfg_auto_i,
  input  logic [NUM_DOM-1:0] cfg_force_on_i,
  input  logic [IDLE_W-1:0]  cfg_idle_thr_i,
  input  logic [NUM_DOM-1:0] busy_i,
  input  logic [NUM_DOM-1:0] wake_req_i,
  output logic [NUM_DOM-1:0] ready_o,
  output logic [NUM_DOM-1:0] gate_en_o,
  output logic               all_off_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IDLE,
    ST_OFF,
    ST_WAKE
  } state_e;

  localparam logic [IDLE_W-1:0] WAKE_LAST = IDLE_W'(WAKE_CYC - 1);

  state_e              r_state     [NUM_DOM];
  logic [IDLE_W-1:0]   r_cnt       [NUM_DOM];
  state_e              w_state_nxt [NUM_DOM];
  logic [IDLE_W-1:0]   w_cnt_nxt   [NUM_DOM];

  logic [NUM_DOM-1:0]  r_gate_en;
  logic [NUM_DOM-1:0]  r_ready;
  logic                r_all_off;
  logic [NUM_DOM-1:0]  w_gate_en_nxt;
  logic [NUM_DOM-1:0]  w_ready_nxt;
  logic [NUM_DOM-1:0]  w_off_nxt;
  logic                w_all_off_nxt;

  logic [NUM_DOM-1:0]  w_stay_on;
  logic [IDLE_W-1:0]   w_thr_last;

  assign w_stay_on  = busy_i | wake_req_i | cfg_force_on_i | ~cfg_auto_i
                    | {NUM_DOM{cfg_idle_thr_i == '0}};
  assign w_thr_last = cfg_idle_thr_i - IDLE_W'(1);

  // State register; output flops share the edge so the gate enables never glitch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned d = 0; d < NUM_DOM; d++) begin
        r_state[d] <= ST_RUN;
        r_cnt[d]   <= '0;
      end
      r_gate_en <= '1;
      r_ready   <= '1;
      r_all_off <= 1'b0;
    end else begin
      for (int unsigned d = 0; d < NUM_DOM; d++) begin
        r_state[d] <= w_state_nxt[d];
        r_cnt[d]   <= w_cnt_nxt[d];
      end
      r_gate_en <= w_gate_en_nxt;
      r_ready   <= w_ready_nxt;
      r_all_off <= w_all_off_nxt;
    end
  end

  always_comb begin
    for (int unsigned d = 0; d < NUM_DOM; d++) begin
      w_state_nxt[d] = r_state[d];
      w_cnt_nxt[d]   = r_cnt[d];
      if (test_en_i) begin
        w_state_nxt[d] = ST_RUN;
        w_cnt_nxt[d]   = '0;
      end else begin
        unique case (r_state[d])
          ST_RUN: begin
            if (!w_stay_on[d]) begin
              w_state_nxt[d] = ST_IDLE;
              w_cnt_nxt[d]   = '0;
            end
          end
          ST_IDLE: begin
            if (w_stay_on[d]) begin
              w_state_nxt[d] = ST_RUN;
              w_cnt_nxt[d]   = '0;
            end else if (r_cnt[d] >= w_thr_last) begin
              w_state_nxt[d] = ST_OFF;
              w_cnt_nxt[d]   = '0;
            end else begin
              w_cnt_nxt[d]   = r_cnt[d] + IDLE_W'(1);
            end
          end
          ST_OFF: begin
            if (w_stay_on[d]) begin
              w_state_nxt[d] = ST_WAKE;
              w_cnt_nxt[d]   = '0;
            end
          end
          ST_WAKE: begin
            if (r_cnt[d] == WAKE_LAST) begin
              w_state_nxt[d] = ST_RUN;
              w_cnt_nxt[d]   = '0;
            end else begin
              w_cnt_nxt[d]   = r_cnt[d] + IDLE_W'(1);
            end
          end
          default: begin
            w_state_nxt[d] = ST_RUN;
            w_cnt_nxt[d]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_gate_en_nxt = '0;
    w_ready_nxt   = '0;
    w_off_nxt     = '0;
    for (int unsigned d = 0; d < NUM_DOM; d++) begin
      w_off_nxt[d]     = (w_state_nxt[d] == ST_OFF);
      w_gate_en_nxt[d] = (w_state_nxt[d] != ST_OFF);
      w_ready_nxt[d]   = (w_state_nxt[d] == ST_RUN) || (w_state_nxt[d] == ST_IDLE);
    end
    w_all_off_nxt = &w_off_nxt;
  end

  assign test_en_o = test_en_i;
  assign gate_en_o = r_gate_en | {NUM_DOM{test_en_i}};
  assign ready_o   = r_ready;
  assign all_off_o = r_all_off;

endmodule
